// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a change amount as individual coins, one coin per ejector
//   handshake. Coins are chosen greedily (20, then 10, then 5), limited by
//   per-denomination stock counters. Reports completion, any unpaid
//   remainder, and which coin tubes are empty.
//
// Ports
//   clk           in   1         system clock, rising edge
//   reset         in   1         synchronous, active-high reset
//   change_valid  in   1         change_in valid
//   change_in     in   CHANGE_W  amount to pay out
//   change_ready  out  1         block can accept a new amount (IDLE only)
//   coin_out      out  3         one-hot coin code: 001=5, 010=10, 100=20
//   coin_valid    out  1         coin_out is being presented to the ejector
//   coin_ack      in   1         ejector has released the presented coin
//   refill        in   1         reload all stocks (honoured in IDLE only)
//   busy          out  1         payout in progress
//   done          out  1         one-cycle pulse: payout finished
//   error         out  1         valid with done: amount not fully paid
//   shortfall     out  CHANGE_W  valid with done: unpaid remainder
//   empty         out  3         per-denomination stock==0 flags
module change_dispenser #(
    parameter int CHANGE_W = 8,
    parameter int CNT_W    = 4,
    parameter int INIT_5   = 8,
    parameter int INIT_10  = 8,
    parameter int INIT_20  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                change_valid,
    input  logic [CHANGE_W-1:0] change_in,
    output logic                change_ready,
    output logic [2:0]          coin_out,
    output logic                coin_valid,
    input  logic                coin_ack,
    input  logic                refill,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CHANGE_W-1:0] shortfall,
    output logic [2:0]          empty
);

    localparam logic [CHANGE_W-1:0] VAL5  = CHANGE_W'(5);
    localparam logic [CHANGE_W-1:0] VAL10 = CHANGE_W'(10);
    localparam logic [CHANGE_W-1:0] VAL20 = CHANGE_W'(20);

    localparam logic [CNT_W-1:0] INIT5_C  = CNT_W'(INIT_5);
    localparam logic [CNT_W-1:0] INIT10_C = CNT_W'(INIT_10);
    localparam logic [CNT_W-1:0] INIT20_C = CNT_W'(INIT_20);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CHANGE_W-1:0] remaining, remaining_next;
    logic [CHANGE_W-1:0] shortfall_reg, shortfall_next;
    logic                error_reg, error_next;
    logic [CNT_W-1:0]    stock5, stock5_next;
    logic [CNT_W-1:0]    stock10, stock10_next;
    logic [CNT_W-1:0]    stock20, stock20_next;
    logic [2:0]          coin_reg, coin_next;
    logic [CHANGE_W-1:0] coin_value;

    // Value of the coin currently held for the ejector.
    always_comb begin
        coin_value = '0;
        if (coin_reg[2]) begin
            coin_value = VAL20;
        end else if (coin_reg[1]) begin
            coin_value = VAL10;
        end else if (coin_reg[0]) begin
            coin_value = VAL5;
        end
    end

    // State and datapath registers. Reset restores full stocks and clears
    // any half-finished payout, so an unacknowledged coin is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remaining     <= '0;
            shortfall_reg <= '0;
            error_reg     <= 1'b0;
            stock5        <= INIT5_C;
            stock10       <= INIT10_C;
            stock20       <= INIT20_C;
            coin_reg      <= 3'b000;
        end else begin
            state         <= state_next;
            remaining     <= remaining_next;
            shortfall_reg <= shortfall_next;
            error_reg     <= error_next;
            stock5        <= stock5_next;
            stock10       <= stock10_next;
            stock20       <= stock20_next;
            coin_reg      <= coin_next;
        end
    end

    // Next-state logic. The result (shortfall/error) is captured on the way
    // into DONE so it is already valid during the done pulse and then simply
    // holds until the next payout finishes.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        shortfall_next = shortfall_reg;
        error_next     = error_reg;
        stock5_next    = stock5;
        stock10_next   = stock10;
        stock20_next   = stock20;
        coin_next      = coin_reg;

        unique case (state)
            IDLE: begin
                if (refill) begin
                    stock5_next  = INIT5_C;
                    stock10_next = INIT10_C;
                    stock20_next = INIT20_C;
                end
                if (change_valid) begin
                    remaining_next = change_in;
                    state_next     = SELECT;
                end
            end

            SELECT: begin
                if (remaining != '0 && remaining >= VAL20 && stock20 != '0) begin
                    coin_next  = 3'b100;
                    state_next = ISSUE;
                end else if (remaining != '0 && remaining >= VAL10 && stock10 != '0) begin
                    coin_next  = 3'b010;
                    state_next = ISSUE;
                end else if (remaining != '0 && remaining >= VAL5 && stock5 != '0) begin
                    coin_next  = 3'b001;
                    state_next = ISSUE;
                end else begin
                    shortfall_next = remaining;
                    error_next     = (remaining != '0);
                    state_next     = DONE;
                end
            end

            ISSUE: begin
                // The coin was only selected if it fit and was in stock, so
                // neither the amount nor the counter can wrap here; the
                // counter guards are kept so stocks can never go below zero.
                if (coin_ack) begin
                    remaining_next = remaining - coin_value;
                    if (coin_reg[2] && stock20 != '0) begin
                        stock20_next = stock20 - ONE_C;
                    end
                    if (coin_reg[1] && stock10 != '0) begin
                        stock10_next = stock10 - ONE_C;
                    end
                    if (coin_reg[0] && stock5 != '0) begin
                        stock5_next = stock5 - ONE_C;
                    end
                    coin_next  = 3'b000;
                    state_next = SELECT;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign change_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign coin_valid   = (state == ISSUE);
    assign done         = (state == DONE);
    assign coin_out     = coin_reg;
    assign error        = error_reg;
    assign shortfall    = shortfall_reg;
    assign empty        = {stock20 == '0, stock10 == '0, stock5 == '0};

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Directed and randomized payouts against a behavioural model that keeps
//   coin stocks as plain integers and pays out greedily with arithmetic.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [7:0] change_in;
    logic       change_ready;
    logic [2:0] coin_out;
    logic       coin_valid;
    logic       coin_ack;
    logic       refill;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] shortfall;
    logic [2:0] empty;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .change_valid (change_valid),
        .change_in    (change_in),
        .change_ready (change_ready),
        .coin_out     (coin_out),
        .coin_valid   (coin_valid),
        .coin_ack     (coin_ack),
        .refill       (refill),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .shortfall    (shortfall),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: stock[0]=5-unit, stock[1]=10-unit, stock[2]=20-unit coins.
    int stock [3];
    int coin_val [3] = '{5, 10, 20};
    int exp_coins [$];
    int exp_short;
    int exp_error;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelRefill();
        for (int i = 0; i < 3; i++) stock[i] = 8;
    endtask

    // Greedy payout: largest coin that fits and is in stock, until nothing fits.
    task automatic modelPayout(input int amount);
        int rem;
        int pick;
        exp_coins.delete();
        rem = amount;
        while (rem > 0) begin
            pick = -1;
            for (int i = 2; i >= 0; i--) begin
                if (pick < 0 && coin_val[i] <= rem && stock[i] > 0) pick = i;
            end
            if (pick < 0) break;
            exp_coins.push_back(pick);
            rem -= coin_val[pick];
            stock[pick]--;
        end
        exp_short = rem;
        exp_error = (rem != 0) ? 1 : 0;
    endtask

    function automatic logic [31:0] modelEmpty();
        return {29'd0, stock[2] == 0, stock[1] == 0, stock[0] == 0};
    endfunction

    task automatic setNoise(input bit noise);
        if (noise) begin
            change_valid = 1'b1;
            change_in    = 8'($urandom_range(255, 0));
            refill       = 1'b1;
        end
    endtask

    // One whole payout, checked cycle by cycle. Entered and left at a
    // negedge with the DUT idle.
    task automatic applyStimulus(input int amount, input int max_delay,
                                 input bit noise, input bit refill_with_accept);
        int d;
        int code;
        checkOutput("ready_idle", 32'(change_ready), 1);
        change_valid = 1'b1;
        change_in    = 8'(amount);
        refill       = refill_with_accept;
        if (refill_with_accept) modelRefill();
        modelPayout(amount);
        @(negedge clk);
        change_valid = 1'b0;
        refill       = 1'b0;
        foreach (exp_coins[k]) begin
            setNoise(noise);
            checkOutput("select_no_coin", 32'(coin_valid), 0);
            checkOutput("select_busy", 32'(busy), 1);
            @(negedge clk);
            setNoise(noise);
            code = 1 << exp_coins[k];
            checkOutput("coin_valid", 32'(coin_valid), 1);
            checkOutput("coin_code", 32'(coin_out), 32'(code));
            d = (max_delay > 0) ? $urandom_range(max_delay, 0) : 0;
            for (int j = 0; j < d; j++) begin
                @(negedge clk);
                setNoise(noise);
                checkOutput("hold_valid", 32'(coin_valid), 1);
                checkOutput("hold_code", 32'(coin_out), 32'(code));
            end
            coin_ack = 1'b1;
            @(negedge clk);
            coin_ack = 1'b0;
        end
        setNoise(noise);
        checkOutput("final_select_done", 32'(done), 0);
        checkOutput("final_select_valid", 32'(coin_valid), 0);
        @(negedge clk);
        setNoise(noise);
        checkOutput("done_pulse", 32'(done), 1);
        checkOutput("done_error", 32'(error), 32'(exp_error));
        checkOutput("done_shortfall", 32'(shortfall), 32'(exp_short));
        @(negedge clk);
        change_valid = 1'b0;
        refill       = 1'b0;
        checkOutput("after_done", 32'(done), 0);
        checkOutput("after_busy", 32'(busy), 0);
        checkOutput("held_shortfall", 32'(shortfall), 32'(exp_short));
        checkOutput("empty", 32'(empty), modelEmpty());
    endtask

    initial begin
        reset        = 1'b1;
        change_valid = 1'b0;
        change_in    = 8'd0;
        coin_ack     = 1'b0;
        refill       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_coin_valid", 32'(coin_valid), 0);
        checkOutput("rst_coin_out", 32'(coin_out), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_error", 32'(error), 0);
        checkOutput("rst_shortfall", 32'(shortfall), 0);
        reset = 1'b0;
        modelRefill();
        @(negedge clk);
        checkOutput("rst_ready", 32'(change_ready), 1);
        checkOutput("rst_empty", 32'(empty), 0);

        $display("[TB] exact change 35, zero amount, odd amount 7");
        applyStimulus(35, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        applyStimulus(7, 0, 1'b0, 1'b0);

        $display("[TB] coin_ack while idle is ignored");
        coin_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("idle_ack_busy", 32'(busy), 0);
            checkOutput("idle_ack_valid", 32'(coin_valid), 0);
        end
        coin_ack = 1'b0;
        checkOutput("idle_ack_empty", 32'(empty), modelEmpty());

        $display("[TB] reset while a coin waits for ack");
        change_valid = 1'b1;
        change_in    = 8'd35;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        checkOutput("stall_valid", 32'(coin_valid), 1);
        checkOutput("stall_code", 32'(coin_out), 4);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_hold_valid", 32'(coin_valid), 1);
            checkOutput("stall_hold_code", 32'(coin_out), 4);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelRefill();
        checkOutput("abort_valid", 32'(coin_valid), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(done), 0);
        end
        checkOutput("abort_ready", 32'(change_ready), 1);
        applyStimulus(40, 1, 1'b0, 1'b0);

        $display("[TB] exhaust 5-unit coins, then busy-time noise");
        for (int n = 0; n < 8 && stock[0] > 0; n++) begin
            applyStimulus(5, 2, 1'b0, 1'b0);
        end
        applyStimulus(5, 0, 1'b1, 1'b0);

        $display("[TB] refill in idle, then low-stock mixes");
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        modelRefill();
        checkOutput("refill_empty", 32'(empty), 0);
        applyStimulus(5, 0, 1'b0, 1'b0);
        applyStimulus(140, 0, 1'b0, 1'b0);
        applyStimulus(60, 1, 1'b0, 1'b0);
        applyStimulus(60, 0, 1'b0, 1'b0);

        $display("[TB] randomized payouts");
        for (int n = 0; n < 25; n++) begin
            applyStimulus($urandom_range(120, 0), $urandom_range(3, 0),
                          1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
